d2d_wrr_arbiter_channel: RTL and testbench
==========================================

# d2d_wrr_arbiter_channel

Weighted round-robin, packet-aware N-to-1 channel arbiter for the die-to-die (D2D) link egress. It sits between the per-channel flit queues and the single D2D serializer input. It grants one channel per cycle with zero request-to-grant latency. A grant is locked from a head flit to its tail flit (wormhole), and each channel may send a programmable burst of packets before priority rotates.

## Interface
Parameters:
- CHANNELS, 4, number of input channels (≥1).
- WEIGHT_W, 4, width of the per-channel weight field.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- request  in  CHANNELS  channel i has a valid flit.
- head  in  CHANNELS  the flit on channel i is a head flit.
- tail  in  CHANNELS  the flit on channel i is a tail flit. head&tail together mark a single-flit packet.
- weight  in  CHANNELS×WEIGHT_W  burst quota of channel i; the channel may send weight[i]+1 consecutive packets.
- out_ready  in  1  downstream accepts the granted flit this cycle.
- grant  out  CHANNELS  one-hot or zero; the selected channel.
- grant_valid  out  1  |grant.
- locked  out  1  a multi-flit packet is in progress.

## Operation
State:
- ptr: log2(CHANNELS) bits, minimum 1. The channel with the highest priority.
- quota_cnt: WEIGHT_W bits. Remaining extra packets for ptr.
- lock_st: IDLE or LOCKED.
- lock_ch: the channel holding the lock.

Grant logic:
- IDLE: grant goes to the first channel with request=1 scanning ptr, ptr+1, … mod CHANNELS.
- LOCKED: grant = onehot(lock_ch) & request[lock_ch]. No re-arbitration. If the locked channel drops its request, the cycle is a bubble.
- A transfer occurs when grant_valid & out_ready.

FSM (g = the granted channel):
- IDLE→LOCKED: a transfer with head[g]&~tail[g]. lock_ch←g.
- LOCKED→IDLE: a transfer with tail[g].
- A transfer with head&tail in IDLE stays in IDLE.

Priority update on every tail transfer from g:
- eff = (g==ptr) ? quota_cnt : weight[g].
- If eff==0: ptr←(g+1) mod CHANNELS and quota_cnt←weight[(g+1) mod CHANNELS].
- Else: ptr←g and quota_cnt←eff−1.
- Non-tail transfers and idle cycles leave ptr and quota_cnt unchanged.
- weight is sampled only at these update edges and at reset. A weight change takes effect at the next reload.

Protocol errors (simulation assertions only; RTL behaviour is defined as follows):
- Tail without head while IDLE is treated as a single-flit packet.
- Head while LOCKED on lock_ch is ignored. The lock holds until the tail.
- Required assertions: $onehot0(grant); grant ⊆ request; while locked, grant ⊆ onehot(lock_ch).

## Timing
- Reset values: ptr=0, quota_cnt=weight[0] (sampled during reset), lock_st=IDLE, locked=0.
- With request=0: grant=0 and grant_valid=0.
- request to grant: combinational, 0 cycles.
- State changes are visible in grant the cycle after the transfer edge.
- Multi-flit packets: the lock applies from the cycle after the head transfer until the tail-transfer cycle inclusive. Arbitration resumes the next cycle.
- out_ready=0: grant is held (it is a function of the unchanged state and request), with no state change.
- Reset mid-packet: the lock clears, ptr=0, and quota reloads. The upstream is responsible for flushing partial packets.
- CHANNELS=1: grant=request. ptr is constant 0. Quota logic is present but has no effect on the grant.

## Test plan
- Reset with weight=0 on all channels and request=4'b1111, out_ready=1, all single-flit: grants go 0,1,2,3,0 on consecutive cycles.
- weight[1]=2, others 0, all single-flit, request=4'b1111: grants go 0,1,1,1,2,3,0.
- Channel 2 sends a 3-flit packet (head, body, tail) while requests 0/1/3 are asserted: grant=4'b0100 for 3 transfers and locked=1 for the last 2. The next grant is 3.
- Locked on channel 1 with request[1] deasserted for 2 cycles mid-packet: grant=0 in those cycles, no other channel is granted, and the lock resumes when request[1] returns.
- out_ready=0 for 5 cycles with request=4'b0110: grant stays 4'b0010 and ptr and quota are unchanged. When out_ready goes high, the transfer and rotation proceed.
- Assert rst while LOCKED on channel 3 with ptr=3: the next cycle gives locked=0, and with request=4'b1001 the grant is 4'b0001.

Source files
------------

// File: rtl/d2d_wrr_arbiter_channel.sv
// d2d_wrr_arbiter_channel
//
// Weighted round-robin, packet-aware N-to-1 arbiter feeding the D2D
// serializer. One channel is granted per cycle, combinationally from the
// request vector. Once a multi-flit packet starts, the grant stays on that
// channel until its tail flit transfers (wormhole). Each channel may send
// weight[i]+1 packets in a row before priority moves to the next channel.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   request      per-channel flit valid
//   head         per-channel head-flit marker
//   tail         per-channel tail-flit marker (head&tail = single-flit packet)
//   weight       per-channel burst quota, WEIGHT_W bits per channel, channel 0 in the LSBs
//   out_ready    downstream accepts the granted flit this cycle
//   grant        one-hot or zero, the selected channel
//   grant_valid  |grant
//   locked       a multi-flit packet is in progress
//
// Lock FSM:
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | no packet open; grant goes to first requester from ptr
//   ST_LOCKED | multi-flit packet open on lock_ch; only lock_ch may be granted

module d2d_wrr_arbiter_channel #(
    parameter int CHANNELS = 4,
    parameter int WEIGHT_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          request,
    input  logic [CHANNELS-1:0]          head,
    input  logic [CHANNELS-1:0]          tail,
    input  logic [CHANNELS*WEIGHT_W-1:0] weight,
    input  logic                         out_ready,
    output logic [CHANNELS-1:0]          grant,
    output logic                         grant_valid,
    output logic                         locked
);

    localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [WEIGHT_W-1:0] QUOTA_ONE = WEIGHT_W'(1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_st_t;

    lock_st_t            lock_st;
    logic [PTR_W-1:0]    lock_ch;
    logic [PTR_W-1:0]    ptr;
    logic [WEIGHT_W-1:0] quota_cnt;

    logic [PTR_W-1:0]    gnt_idx;
    logic                gnt_any;
    logic                xfer;
    logic                is_tail;
    logic [PTR_W-1:0]    nxt_ch;
    logic [WEIGHT_W-1:0] eff;
    logic [WEIGHT_W-1:0] nxt_weight;

    // (a + b) mod CHANNELS for small b; indices never exceed CHANNELS-1.
    function automatic logic [PTR_W-1:0] ch_add(input logic [PTR_W-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= CHANNELS) s = s - CHANNELS;
        return s[PTR_W-1:0];
    endfunction

    function automatic logic [WEIGHT_W-1:0] weight_of(input logic [PTR_W-1:0] ch);
        return weight[int'(ch)*WEIGHT_W +: WEIGHT_W];
    endfunction

    // Channel selection: locked channel only, or a rotating scan from ptr.
    always_comb begin
        gnt_idx = ptr;
        gnt_any = 1'b0;
        if (lock_st == ST_LOCKED) begin
            gnt_idx = lock_ch;
            gnt_any = request[lock_ch];
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (!gnt_any && request[ch_add(ptr, k)]) begin
                    gnt_idx = ch_add(ptr, k);
                    gnt_any = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant          = '0;
        grant[gnt_idx] = gnt_any;
    end

    assign grant_valid = gnt_any;
    assign locked      = (lock_st == ST_LOCKED);

    assign xfer       = gnt_any & out_ready;
    assign is_tail    = tail[gnt_idx];
    assign nxt_ch     = ch_add(gnt_idx, 1);
    assign nxt_weight = weight_of(nxt_ch);
    // The running quota only belongs to ptr; any other channel starts a fresh burst.
    assign eff        = (gnt_idx == ptr) ? quota_cnt : weight_of(gnt_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_st   <= ST_IDLE;
            lock_ch   <= '0;
            ptr       <= '0;
            quota_cnt <= weight_of('0);
        end else if (xfer) begin
            if (is_tail) begin
                // Tail closes the packet (a headless tail in IDLE counts as a
                // single-flit packet) and charges one packet to the burst.
                lock_st <= ST_IDLE;
                if (eff == '0) begin
                    ptr       <= nxt_ch;
                    quota_cnt <= nxt_weight;
                end else begin
                    ptr       <= gnt_idx;
                    quota_cnt <= eff - QUOTA_ONE;
                end
            end else if (lock_st == ST_IDLE && head[gnt_idx]) begin
                lock_st <= ST_LOCKED;
                lock_ch <= gnt_idx;
            end
        end
    end

`ifndef SYNTHESIS
    logic [CHANNELS-1:0] lock_mask;

    always_comb begin
        lock_mask          = '0;
        lock_mask[lock_ch] = 1'b1;
    end

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(grant));
    a_grant_in_request : assert property (@(posedge clk) disable iff (rst)
        (grant & ~request) == '0);
    a_grant_in_lock : assert property (@(posedge clk) disable iff (rst)
        locked |-> ((grant & ~lock_mask) == '0));
`endif

endmodule

// File: tb/tb_d2d_wrr_arbiter_channel.sv
// Bench for d2d_wrr_arbiter_channel: directed scenarios with literal grant
// expectations, then randomized traffic. A packet-level model (burst owner,
// packets sent vs. burst budget, open packet channel) predicts grant,
// grant_valid and locked on every non-reset cycle.
module tb_d2d_wrr_arbiter_channel;
    localparam int CH = 4;
    localparam int WW = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [CH-1:0]    request;
    logic [CH-1:0]    head;
    logic [CH-1:0]    tail;
    logic [CH*WW-1:0] weight;
    logic             out_ready;
    logic [CH-1:0]    grant;
    logic             grant_valid;
    logic             locked;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    d2d_wrr_arbiter_channel #(.CHANNELS(CH), .WEIGHT_W(WW)) dut (
        .clk(clk),
        .rst(rst),
        .request(request),
        .head(head),
        .tail(tail),
        .weight(weight),
        .out_ready(out_ready),
        .grant(grant),
        .grant_valid(grant_valid),
        .locked(locked)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_ok = 0;
    int m_owner, m_sent, m_budget, m_lock_ch;
    bit m_locked;

    function automatic int wt(input int i);
        return int'(weight[i*WW +: WW]);
    endfunction

    always @(negedge clk) begin
        int g;
        logic [CH-1:0] e;
        if (rst) begin
            m_ok     = 1;
            m_owner  = 0;
            m_sent   = 0;
            m_budget = wt(0) + 1;
            m_locked = 0;
            m_lock_ch = 0;
        end else if (m_ok) begin
            g = -1;
            if (m_locked) begin
                if (request[m_lock_ch]) g = m_lock_ch;
            end else begin
                for (int k = 0; k < CH; k++) begin
                    if (g < 0 && request[(m_owner + k) % CH]) g = (m_owner + k) % CH;
                end
            end
            e = '0;
            if (g >= 0) e[g] = 1'b1;
            chk("model_grant", int'(grant), int'(e));
            chk("model_grant_valid", int'(grant_valid), (g >= 0) ? 1 : 0);
            chk("model_locked", int'(locked), int'(m_locked));
            if (g >= 0 && out_ready) begin
                if (tail[g]) begin
                    m_locked = 0;
                    if (g != m_owner) begin
                        m_owner  = g;
                        m_budget = wt(g) + 1;
                        m_sent   = 0;
                    end
                    m_sent++;
                    if (m_sent == m_budget) begin
                        m_owner  = (g + 1) % CH;
                        m_budget = wt(m_owner) + 1;
                        m_sent   = 0;
                    end
                end else if (!m_locked && head[g]) begin
                    m_locked  = 1;
                    m_lock_ch = g;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Drive one cycle; exp_g/exp_lk < 0 means no literal check that cycle.
    task automatic step(input logic [CH-1:0] req, input logic [CH-1:0] hd,
                        input logic [CH-1:0] tl, input logic rdy,
                        input int exp_g, input int exp_lk, input string nm);
        request   = req;
        head      = hd;
        tail      = tl;
        out_ready = rdy;
        @(negedge clk);
        if (exp_g >= 0) chk({nm, "_grant"}, int'(grant), exp_g);
        if (exp_lk >= 0) chk({nm, "_locked"}, int'(locked), exp_lk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step('0, '0, '0, 1'b1, -1, -1, "rst");
        step('0, '0, '0, 1'b1, -1, -1, "rst");
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        rst = 1'b1; request = '0; head = '0; tail = '0; out_ready = 1'b1; weight = '0;

        // reset state, then plain round robin
        do_reset();
        step(4'b0000, '1, '1, 1'b1, 4'b0000, 0, "reset_idle");
        chk("reset_grant_valid", int'(grant_valid), 0);
        step(4'b1111, '1, '1, 1'b1, 4'b0001, 0, "rr0");
        step(4'b1111, '1, '1, 1'b1, 4'b0010, 0, "rr1");
        step(4'b1111, '1, '1, 1'b1, 4'b0100, 0, "rr2");
        step(4'b1111, '1, '1, 1'b1, 4'b1000, 0, "rr3");
        step(4'b1111, '1, '1, 1'b1, 4'b0001, 0, "rr4");

        // weight[1]=2: channel 1 gets three packets in a row
        weight = 16'h0020;
        do_reset();
        step(4'b1111, '1, '1, 1'b1, 4'b0001, -1, "w0");
        step(4'b1111, '1, '1, 1'b1, 4'b0010, -1, "w1");
        step(4'b1111, '1, '1, 1'b1, 4'b0010, -1, "w2");
        step(4'b1111, '1, '1, 1'b1, 4'b0010, -1, "w3");
        step(4'b1111, '1, '1, 1'b1, 4'b0100, -1, "w4");
        step(4'b1111, '1, '1, 1'b1, 4'b1000, -1, "w5");
        step(4'b1111, '1, '1, 1'b1, 4'b0001, -1, "w6");

        // 3-flit packet on channel 2
        weight = '0;
        do_reset();
        step(4'b1111, '1, '1, 1'b1, 4'b0001, -1, "pre0");
        step(4'b1111, '1, '1, 1'b1, 4'b0010, -1, "pre1");
        step(4'b1111, 4'b1111, 4'b1011, 1'b1, 4'b0100, 0, "pkt_head");
        step(4'b1111, 4'b1011, 4'b1011, 1'b1, 4'b0100, 1, "pkt_body");
        step(4'b1111, 4'b1011, 4'b1111, 1'b1, 4'b0100, 1, "pkt_tail");
        step(4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b1000, 0, "pkt_next");

        // locked on channel 1, request drops for two cycles
        step(4'b0010, 4'b0010, 4'b0000, 1'b1, 4'b0010, 0, "bub_head");
        step(4'b1101, 4'b1101, 4'b1101, 1'b1, 4'b0000, 1, "bub_gap0");
        step(4'b1101, 4'b1101, 4'b1101, 1'b1, 4'b0000, 1, "bub_gap1");
        step(4'b1111, 4'b1101, 4'b1101, 1'b1, 4'b0010, 1, "bub_body");
        step(4'b1111, 4'b1101, 4'b1111, 1'b1, 4'b0010, 1, "bub_tail");
        step(4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b0100, 0, "bub_next");

        // backpressure: ptr=3, request 0110 held with out_ready low
        for (int i = 0; i < 5; i++)
            step(4'b0110, '1, '1, 1'b0, 4'b0010, 0, "stall");
        step(4'b0110, '1, '1, 1'b1, 4'b0010, 0, "stall_go");
        step(4'b0110, '1, '1, 1'b1, 4'b0100, 0, "stall_rot");
        step(4'b0110, '1, '1, 1'b1, 4'b0010, 0, "stall_wrap");

        // reset in the middle of a packet on channel 3 with ptr=3
        step(4'b0100, '1, '1, 1'b1, 4'b0100, 0, "mr_pre");
        step(4'b1000, 4'b1000, 4'b0000, 1'b1, 4'b1000, 0, "mr_head");
        step(4'b1000, 4'b0000, 4'b0000, 1'b1, 4'b1000, 1, "mr_body");
        rst = 1'b1;
        step(4'b1000, 4'b0000, 4'b0000, 1'b1, -1, -1, "mr_rst");
        rst = 1'b0;
        step(4'b1001, 4'b1001, 4'b1001, 1'b1, 4'b0001, 0, "mr_after");

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            logic [CH-1:0] rq, hd, tl;
            logic rdy;
            if ($urandom_range(0, 39) == 0) begin
                r = $urandom;
                weight = r[CH*WW-1:0] & 16'h3333;
            end
            rst = ($urandom_range(0, 299) == 0);
            r = $urandom;
            rq  = r[3:0] | r[7:4];
            hd  = r[11:8] & r[15:12];
            tl  = r[19:16] & (r[23:20] | r[27:24]);
            rdy = ($urandom_range(0, 3) != 0);
            step(rq, hd, tl, rdy, -1, -1, "rand");
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
